sw_alloc: RTL and testbench



---
 rtl/sw_alloc_pkg.sv | 24 ++
 rtl/sw_alloc_if.sv | 30 +++
 rtl/sw_alloc_rr_arb.sv | 36 +++
 rtl/sw_alloc.sv | 124 ++++++++++++
 tb/tb_sw_alloc.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sw_alloc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sw_alloc_pkg
// Purpose : Shared port encodings, sizes and output-FSM state codes.
// Rev     : 1.0
// ============================================================================
package sw_alloc_pkg;

    localparam int NPORT = 5;
    localparam int PORTW = 3;

    localparam logic [PORTW-1:0] PORT_N = 3'd0;
    localparam logic [PORTW-1:0] PORT_E = 3'd1;
    localparam logic [PORTW-1:0] PORT_S = 3'd2;
    localparam logic [PORTW-1:0] PORT_W = 3'd3;
    localparam logic [PORTW-1:0] PORT_L = 3'd4;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    typedef logic [PORTW-1:0] port_idx_t;

endpackage
`default_nettype wire

// File: rtl/sw_alloc_if.sv
`default_nettype none
// ============================================================================
// Module  : sw_alloc_if
// Purpose : Route-compute / credit side bundle into the switch allocator.
// Rev     : 1.0
// ============================================================================
interface sw_alloc_if #(
    parameter int NPORT = sw_alloc_pkg::NPORT,
    parameter int PORTW = sw_alloc_pkg::PORTW
);
    logic [NPORT-1:0]       req;
    logic [NPORT*PORTW-1:0] req_port;
    logic [NPORT-1:0]       req_tail;
    logic [NPORT-1:0]       credit_in;
    logic [NPORT-1:0]       grant;
    logic [NPORT-1:0]       out_valid;
    logic [NPORT*PORTW-1:0] out_sel;
    logic                   credit_err;

    modport master (
        output req, req_port, req_tail, credit_in,
        input  grant, out_valid, out_sel, credit_err
    );

    modport slave (
        input  req, req_port, req_tail, credit_in,
        output grant, out_valid, out_sel, credit_err
    );
endinterface
`default_nettype wire

// File: rtl/sw_alloc_rr_arb.sv
`default_nettype none
// ============================================================================
// Module  : sw_alloc_rr_arb
// Purpose : Round-robin arbiter; scans from ptr+1 with wrap-around.
// Rev     : 1.0
// ============================================================================
module sw_alloc_rr_arb
    import sw_alloc_pkg::*;
#(
    parameter int N = NPORT,
    parameter int W = PORTW
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] win,
    output logic         any
);

    // Scan farthest-first so the nearest requester after ptr overwrites last.
    always_comb begin
        gnt = '0;
        win = '0;
        any = 1'b0;
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                gnt                        = '0;
                gnt[(int'(ptr) + k) % N]   = 1'b1;
                win                        = W'((int'(ptr) + k) % N);
                any                        = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sw_alloc.sv
`default_nettype none
// ============================================================================
// Module  : sw_alloc
// Purpose : Per-output round-robin, wormhole-locked, credit-gated allocator.
// Rev     : 1.0
// ============================================================================
module sw_alloc #(
    parameter int NPORT     = 5,
    parameter int PORTW     = 3,
    parameter int BUF_DEPTH = 4,
    parameter int CNTW      = 3
) (
    input  logic    clk,
    input  logic    rst_,
    sw_alloc_if.slave bus
);
    import sw_alloc_pkg::*;

    logic [NPORT-1:0]       w_gnt_vec [NPORT];
    logic [NPORT-1:0]       w_fire;
    logic [NPORT-1:0]       w_ovf;
    port_idx_t              w_win     [NPORT];
    logic [NPORT-1:0]       w_grant;
    logic [NPORT*PORTW-1:0] w_sel;
    logic                   r_credit_err;

    generate
        for (genvar o = 0; o < NPORT; o++) begin : g_out
            logic [0:0]       r_state;
            logic [PORTW-1:0] r_owner;
            logic [PORTW-1:0] r_ptr;
            logic [CNTW-1:0]  r_credit;
            logic [NPORT-1:0] w_cand;
            logic [NPORT-1:0] w_arb_gnt;
            logic [PORTW-1:0] w_arb_win;
            logic             w_arb_any;
            logic             w_locked;
            logic             w_tail;
            logic [CNTW-1:0]  w_credit_nxt;
            logic             w_ovf_l;

            // Out-of-range req_port values never equal o, so they drop out here.
            always_comb begin
                w_cand = '0;
                for (int i = 0; i < NPORT; i++) begin
                    w_cand[i] = bus.req[i] && (bus.req_port[i*PORTW +: PORTW] == PORTW'(o));
                end
            end

            sw_alloc_rr_arb #(.N(NPORT), .W(PORTW)) u_arb (
                .req (w_cand),
                .ptr (r_ptr),
                .gnt (w_arb_gnt),
                .win (w_arb_win),
                .any (w_arb_any)
            );

            assign w_locked     = (r_state == ST_LOCKED);
            assign w_fire[o]    = (r_credit != '0) && (w_locked ? w_cand[r_owner] : w_arb_any);
            assign w_win[o]     = w_locked ? r_owner : w_arb_win;
            assign w_tail       = bus.req_tail[w_win[o]];
            assign w_gnt_vec[o] = !w_fire[o] ? '0 :
                                  (w_locked ? (NPORT'(1) << r_owner) : w_arb_gnt);
            assign w_ovf[o]     = w_ovf_l;

            always_comb begin
                w_credit_nxt = r_credit;
                w_ovf_l      = 1'b0;
                case ({w_fire[o], bus.credit_in[o]})
                    2'b10: w_credit_nxt = r_credit - CNTW'(1);
                    2'b01: begin
                        if (r_credit == CNTW'(BUF_DEPTH)) w_ovf_l = 1'b1;
                        else                              w_credit_nxt = r_credit + CNTW'(1);
                    end
                    default: ;
                endcase
            end

            always_ff @(posedge clk or negedge rst_) begin
                if (!rst_) begin
                    r_state  <= ST_IDLE;
                    r_owner  <= '0;
                    r_ptr    <= PORTW'(NPORT - 1);
                    r_credit <= CNTW'(BUF_DEPTH);
                end else begin
                    r_credit <= w_credit_nxt;
                    if (w_fire[o]) begin
                        if (!w_locked) begin
                            r_ptr <= w_win[o];
                            if (!w_tail) begin
                                r_state <= ST_LOCKED;
                                r_owner <= w_win[o];
                            end
                        end else if (w_tail) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        w_grant = '0;
        w_sel   = '0;
        for (int o = 0; o < NPORT; o++) begin
            w_grant |= w_gnt_vec[o];
            if (w_fire[o]) w_sel[o*PORTW +: PORTW] = w_win[o];
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_)       r_credit_err <= 1'b0;
        else if (|w_ovf) r_credit_err <= 1'b1;
    end

    // Outputs are forced low while reset is held so a mid-packet reset drops them at once.
    assign bus.grant      = rst_ ? w_grant : '0;
    assign bus.out_valid  = rst_ ? w_fire  : '0;
    assign bus.out_sel    = rst_ ? w_sel   : '0;
    assign bus.credit_err = r_credit_err;

endmodule
`default_nettype wire

// File: tb/tb_sw_alloc.sv
`default_nettype none
// ============================================================================
// Module  : tb_sw_alloc
// Purpose : Directed + random bench for sw_alloc against a behavioural model.
// Rev     : 1.0
// ============================================================================
module tb_sw_alloc;
    import sw_alloc_pkg::*;

    localparam int N     = 5;
    localparam int W     = 3;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_;
    always #5 clk = ~clk;

    sw_alloc_if #(.NPORT(N), .PORTW(W)) bus ();

    sw_alloc #(.NPORT(N), .PORTW(W), .BUF_DEPTH(DEPTH), .CNTW(3)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit m_locked [N];
    int m_owner  [N];
    int m_ptr    [N];
    int m_credit [N];
    bit m_err;
    logic [N-1:0] last_g;

    int exp_rr [6] = '{0, 1, 3, 0, 1, 3};
    bit t3_req [5] = '{1, 0, 1, 1, 0};
    bit t3_tl  [5] = '{0, 0, 0, 1, 0};
    bit t3_cin [5] = '{1, 0, 1, 1, 1};
    int t3_exp [5] = '{1, 0, 1, 1, 2};
    int cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int port_of(input int i);
        return int'(bus.req_port[i*W +: W]);
    endfunction

    task automatic model_reset();
        for (int o = 0; o < N; o++) begin
            m_locked[o] = 1'b0;
            m_owner[o]  = 0;
            m_ptr[o]    = N - 1;
            m_credit[o] = DEPTH;
        end
        m_err = 1'b0;
    endtask

    task automatic set_in(input int i, input bit r, input int p, input bit t);
        bus.req[i]              = r;
        bus.req_port[i*W +: W]  = W'(p);
        bus.req_tail[i]         = t;
    endtask

    task automatic clear_in();
        bus.req       = '0;
        bus.req_port  = '0;
        bus.req_tail  = '0;
        bus.credit_in = '0;
    endtask

    // One cycle: predict and compare at the negedge, advance the model, move past posedge.
    task automatic step();
        logic [N-1:0]   eg, ev;
        logic [N*W-1:0] es;
        int w;
        @(negedge clk);
        check("credit_err", bus.credit_err, m_err);
        eg = '0; ev = '0; es = '0;
        for (int o = 0; o < N; o++) begin
            w = -1;
            if (m_credit[o] > 0) begin
                if (m_locked[o]) begin
                    if (bus.req[m_owner[o]] && port_of(m_owner[o]) == o) w = m_owner[o];
                end else begin
                    for (int k = 1; k <= N; k++) begin
                        int i = (m_ptr[o] + k) % N;
                        if (w < 0 && bus.req[i] && port_of(i) == o) w = i;
                    end
                end
            end
            if (w >= 0) begin
                eg[w] = 1'b1;
                ev[o] = 1'b1;
                es[o*W +: W] = W'(w);
                if (!m_locked[o]) begin
                    m_ptr[o] = w;
                    if (!bus.req_tail[w]) begin
                        m_locked[o] = 1'b1;
                        m_owner[o]  = w;
                    end
                end else if (bus.req_tail[w]) begin
                    m_locked[o] = 1'b0;
                end
            end
            if (ev[o] && !bus.credit_in[o]) m_credit[o]--;
            else if (!ev[o] && bus.credit_in[o]) begin
                if (m_credit[o] == DEPTH) m_err = 1'b1;
                else                      m_credit[o]++;
            end
        end
        check("grant", bus.grant, eg);
        check("out_valid", bus.out_valid, ev);
        check("out_sel", bus.out_sel, es);
        last_g = bus.grant;
        @(posedge clk);
        #1;
    endtask

    // Reset with all inputs requesting, to see outputs held low during reset.
    task automatic do_reset();
        rst_ = 1'b0;
        clear_in();
        bus.req = '1;
        #2;
        check("rst_grant", bus.grant, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_sel", bus.out_sel, 0);
        check("rst_credit_err", bus.credit_err, 0);
        clear_in();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_ = 1'b1;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ = 1'b0;
        clear_in();
        model_reset();
        do_reset();

        // Single-flit packet
        set_in(2, 1'b1, PORT_E, 1'b1);
        step();
        check("t1_grant", last_g, 5'b00100);
        clear_in();
        step();

        // Round-robin fairness on the local output
        do_reset();
        set_in(0, 1'b1, PORT_L, 1'b1);
        set_in(1, 1'b1, PORT_L, 1'b1);
        set_in(3, 1'b1, PORT_L, 1'b1);
        bus.credit_in = 5'b10000;
        for (int k = 0; k < 6; k++) begin
            step();
            check("t2_rr", last_g, 32'(1) << exp_rr[k]);
        end
        clear_in();
        step();

        // Wormhole lock with a bubble
        do_reset();
        set_in(1, 1'b1, PORT_S, 1'b1);
        for (int c = 0; c < 5; c++) begin
            set_in(0, t3_req[c], PORT_S, t3_tl[c]);
            bus.credit_in[2] = t3_cin[c];
            step();
            check("t3_lock", last_g, (t3_exp[c] == 0) ? 32'd0 : (32'd1 << (t3_exp[c] - 1)));
        end
        clear_in();
        step();

        // Credit exhaustion then one refill
        do_reset();
        set_in(4, 1'b1, PORT_N, 1'b0);
        cnt = 0;
        repeat (8) begin step(); cnt += int'(last_g[4]); end
        check("t4_first_burst", cnt, 4);
        cnt = 0;
        bus.credit_in[0] = 1'b1;
        step();
        cnt += int'(last_g[4]);
        bus.credit_in[0] = 1'b0;
        repeat (3) begin step(); cnt += int'(last_g[4]); end
        check("t4_refill", cnt, 1);
        clear_in();

        // Concurrent outputs and credit overflow
        do_reset();
        for (int i = 0; i < N; i++) set_in(i, 1'b1, (i + 1) % N, 1'b1);
        step();
        check("t5_all", last_g, 5'h1f);
        clear_in();
        bus.credit_in = 5'b01000;
        step();
        step();
        bus.credit_in = '0;
        step();
        check("t5_err", bus.credit_err, 1);
        set_in(0, 1'b1, PORT_W, 1'b0);
        cnt = 0;
        repeat (6) begin step(); cnt += int'(last_g[0]); end
        check("t5_credit_full", cnt, 4);
        clear_in();

        // Asynchronous reset while output 2 is locked
        do_reset();
        set_in(0, 1'b1, PORT_S, 1'b0);
        step();
        step();
        set_in(1, 1'b1, PORT_S, 1'b1);
        #2;
        rst_ = 1'b0;
        #1;
        check("t6_grant_async", bus.grant, 0);
        check("t6_valid_async", bus.out_valid, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_ = 1'b1;
        step();
        check("t6_first", last_g, 5'b00001);
        clear_in();
        step();

        // Randomized traffic against the model
        do_reset();
        repeat (400) begin
            for (int i = 0; i < N; i++) begin
                set_in(i, 1'($urandom), int'($urandom_range(7)), 1'($urandom));
                bus.credit_in[i] = ($urandom_range(3) == 0);
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
